// File: rtl/bambu_tb_pkg.sv
// Shared types and defaults for the bambu memory loader: FSM states and word geometry.
package bambu_tb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        START,
        RUN,
        REPORT
    } state_t;

    localparam int DEF_DATA_W     = 64;
    localparam int BYTES_PER_WORD = DEF_DATA_W / 8;
    localparam int DEF_MAX_CYCLES = 200000000;

endpackage

// File: rtl/byte_packer.sv
// Packs an incoming byte stream little-endian into one slave-RAM word and tracks
// how many lanes are filled and whether the word carries the final byte.
module byte_packer
    import bambu_tb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANE_W = $clog2(DATA_W / 8 + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              accept,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    input  logic              clear,
    output logic [DATA_W-1:0] data,
    output logic [LANE_W-1:0] lanes,
    output logic              last,
    output logic              closing
);

    localparam int LANES = DATA_W / 8;

    // The byte being accepted now completes the word (last lane or end of stream).
    assign closing = accept && (byte_last || lanes == LANE_W'(LANES - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            data  <= '0;
            lanes <= '0;
            last  <= 1'b0;
        end else if (accept) begin
            data[{lanes, 3'b000} +: 8] <= byte_data;
            lanes                      <= lanes + LANE_W'(1);
            last                       <= byte_last;
        end
    end

endmodule

// File: rtl/bambu_mem_loader.sv
// Loads a byte image into main's slave RAM word by word, starts main and times the
// run until done_port, reporting the cycle count or a timeout.
module bambu_mem_loader
    import bambu_tb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SIZE_W     = 7,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              S_oe_ram,
    output logic              S_we_ram,
    output logic [ADDR_W-1:0] S_addr_ram,
    output logic [DATA_W-1:0] S_Wdata_ram,
    output logic [SIZE_W-1:0] S_data_ram_size,
    input  logic              Sout_DataRdy,
    output logic              start_port,
    input  logic              done_port,
    output logic [31:0]       cycle_count,
    output logic              run_done,
    output logic              timeout
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES + 1);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   addr;
    logic [31:0]         count;
    logic                accept, ack;
    logic [LANE_W-1:0]   lanes;
    logic                word_last, closing;

    assign accept = byte_valid && byte_ready;
    assign ack    = (state == WRITE) && Sout_DataRdy;

    byte_packer #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_packer (
        .clock     (clock),
        .reset     (reset),
        .accept    (accept),
        .byte_data (byte_data),
        .byte_last (byte_last),
        .clear     (ack),
        .data      (S_Wdata_ram),
        .lanes     (lanes),
        .last      (word_last),
        .closing   (closing)
    );

    assign S_oe_ram        = 1'b0;
    assign S_addr_ram      = addr;
    assign S_data_ram_size = SIZE_W'({lanes, 3'b000});

    always_comb begin
        state_next = state;
        case (state)
            IDLE, FILL: if (accept) state_next = closing ? WRITE : FILL;
            WRITE:      if (Sout_DataRdy) state_next = word_last ? START : FILL;
            START:      state_next = RUN;
            RUN:        if (done_port || count == 32'(MAX_CYCLES)) state_next = REPORT;
            REPORT:     state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            count       <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            byte_ready  <= 1'b1;
            S_we_ram    <= 1'b0;
            start_port  <= 1'b0;
            run_done    <= 1'b0;
        end else begin
            state      <= state_next;
            byte_ready <= (state_next == IDLE) || (state_next == FILL);
            S_we_ram   <= (state_next == WRITE);
            start_port <= (state_next == START);
            run_done   <= (state_next == REPORT);

            if (state == IDLE && accept)
                addr <= base_addr;
            else if (ack)
                addr <= addr + ADDR_W'(LANES);

            case (state)
                START: begin
                    count       <= 32'd1;
                    cycle_count <= '0;
                    timeout     <= 1'b0;
                end
                RUN: begin
                    if (done_port) begin
                        cycle_count <= count;
                    end else if (count == 32'(MAX_CYCLES)) begin
                        timeout     <= 1'b1;
                        cycle_count <= 32'(MAX_CYCLES);
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
